// File: rtl/dtcm_ctrl_if.sv
// LSU <-> DTCM cmd/rsp bundle.
// The master drives commands; the slave returns one response per accepted command.
interface dtcm_ctrl_if #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16
);
  logic                       dtcm_cmd_valid;
  logic                       dtcm_cmd_ready;
  logic                       dtcm_cmd_read;
  logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr;
  logic [XLEN-1:0]            dtcm_cmd_wdata;
  logic [XLEN/8-1:0]          dtcm_cmd_wmask;
  logic                       dtcm_rsp_valid;
  logic                       dtcm_rsp_ready;
  logic [XLEN-1:0]            dtcm_rsp_rdata;
  logic                       dtcm_rsp_err;

  modport master (
    output dtcm_cmd_valid,
    output dtcm_cmd_read,
    output dtcm_cmd_addr,
    output dtcm_cmd_wdata,
    output dtcm_cmd_wmask,
    output dtcm_rsp_ready,
    input  dtcm_cmd_ready,
    input  dtcm_rsp_valid,
    input  dtcm_rsp_rdata,
    input  dtcm_rsp_err
  );

  modport slave (
    input  dtcm_cmd_valid,
    input  dtcm_cmd_read,
    input  dtcm_cmd_addr,
    input  dtcm_cmd_wdata,
    input  dtcm_cmd_wmask,
    input  dtcm_rsp_ready,
    output dtcm_cmd_ready,
    output dtcm_rsp_valid,
    output dtcm_rsp_rdata,
    output dtcm_rsp_err
  );
endinterface

// File: rtl/dtcm_ctrl.sv
// Data TCM responder: byte-masked writes and word reads,
// one-cycle response latency through a single-entry response register.
module dtcm_ctrl #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int DTCM_DEPTH      = 4096
) (
  input logic        clk,
  input logic        rst_n,
  dtcm_ctrl_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int IXW = DTCM_ADDR_WIDTH - 2;
  localparam int IW =
    (DTCM_DEPTH > 1) ? $clog2(DTCM_DEPTH) : 1;
  localparam logic [IXW:0] DEPTH_W =
    (IXW + 1)'(DTCM_DEPTH);

  logic [XLEN-1:0] mem_q [DTCM_DEPTH];

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic           cmd_ready;
  logic           cmd_hsk;
  logic           rsp_hsk;
  logic [IXW-1:0] idx;
  logic [IW-1:0]  widx;
  logic           in_range;
  logic           unused_addr;

  assign idx  = bus.dtcm_cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign widx = idx[IW-1:0];
  assign in_range = {1'b0, idx} < DEPTH_W;
  assign unused_addr = ^bus.dtcm_cmd_addr;

  // Pass-through: a draining response frees the slot this cycle.
  assign cmd_ready = ~rsp_valid_q | bus.dtcm_rsp_ready;
  assign cmd_hsk   = bus.dtcm_cmd_valid & cmd_ready;
  assign rsp_hsk   = rsp_valid_q & bus.dtcm_rsp_ready;

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (cmd_hsk) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = ~in_range;
      rsp_rdata_d = '0;
      if (bus.dtcm_cmd_read && in_range) begin
        rsp_rdata_d = mem_q[widx];
      end
    end else if (rsp_hsk) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (cmd_hsk && !bus.dtcm_cmd_read && in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.dtcm_cmd_wmask[i]) begin
          mem_q[widx][8*i +: 8] <=
            bus.dtcm_cmd_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.dtcm_cmd_ready = cmd_ready;
  assign bus.dtcm_rsp_valid = rsp_valid_q;
  assign bus.dtcm_rsp_rdata = rsp_rdata_q;
  assign bus.dtcm_rsp_err   = rsp_err_q;
endmodule
